pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit: the source of stall_sign consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
//  Merges stall requests from IF/ID/EX/MEM, flushes wrong-path instructions on taken branches, and sequences the PC redirect.
//  If a fetch is still outstanding when a branch resolves, the redirect is held until that fetch completes.
//  Also keeps a saturating stall-cycle counter.
// PARAMETERS
//  ADDR_W  32  width of PC / redirect target
//  CNT_W   16  width of stall-cycle counter
// PORTS
//  clk             in   1       single clock, all state on posedge
//  rst             in   1       asynchronous, active-low reset (0 = reset)
//  req_if          in   1       fetch not ready (instruction port busy)
//  req_id          in   1       load-use hazard detected in ID
//  req_ex          in   1       multi-cycle EX op in progress
//  req_mem         in   1       memory access not complete
//  if_busy         in   1       fetch request outstanding on memory port
//  ex_branch       in   1       EX resolved a taken branch/jump this cycle
//  ex_target       in   ADDR_W  branch/jump target from EX
//  stall_sign      out  6       [0]pc [1]if [2]if_id [3]id_ex [4]ex_mem [5]mem_wb; 1 = hold
//  flush_if_id     out  1       load bubble into if_id
//  flush_id_ex     out  1       load bubble into id_ex
//  redirect_valid  out  1       one-cycle pulse: pc_reg loads redirect_addr
//  redirect_addr   out  ADDR_W  new PC, valid with redirect_valid
//  stall_clr       in   1       synchronous clear of stall_cycles
//  stall_cycles    out  CNT_W   cycles with stall_sign != 0, saturating
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN, redirect_valid=0, redirect_addr=0, stall_cycles=0, pending target=0.
//   Combinational outputs follow from these: stall_sign=0 while reset held.
//  stall_sign (combinational, 0-cycle); the highest-priority request wins:
//   req_mem -> 6'b011111
//   req_ex  -> 6'b001111
//   req_id  -> 6'b000111
//   req_if  -> 6'b000011
//   none    -> 6'b000000
//  Stage k+1 is not stalled while stage k is; the downstream register inserts a bubble.
//  Branch accepted = ex_branch & ~stall_sign[4] & state==RUN.
//   ex_branch in HOLD is ignored; it cannot occur because id_ex was flushed.
//  FSM states: RUN, HOLD.
//   RUN, branch accepted, if_busy=0:
//    flush_if_id=1 and flush_id_ex=1 same cycle (combinational).
//    Next cycle: redirect_valid=1, redirect_addr=ex_target; stay RUN.
//   RUN, branch accepted, if_busy=1:
//    flush_if_id=1 and flush_id_ex=1 same cycle.
//    Latch ex_target; next state HOLD.
//   HOLD:
//    stall_sign[0] forced 1 (OR'ed with the request mapping).
//    flush_if_id held 1 so the late wrong-path instruction is dropped.
//   HOLD, if_busy=0:
//    Next cycle: redirect_valid=1, redirect_addr=latched target; state RUN.
//    flush_if_id stays 1 in the exiting cycle.
//   HOLD, if_busy=1: remain HOLD.
//  Redirect pulse coincides with req_* stalls: the pulse is still issued.
//   pc_reg gives redirect priority over stall_sign[0].
//  redirect_valid lasts exactly one cycle; redirect_addr holds its last value afterwards.
//  stall_cycles:
//   +1 on each posedge with stall_sign!=0.
//   Saturates at 2^CNT_W-1 (no wrap).
//   stall_clr=1 zeroes it and overrides increment that cycle.
//  Reset mid-HOLD: the latched target is discarded and no redirect issues.
// TESTING
//  1 req_id=1 only -> stall_sign=6'b000111 same cycle; req_mem&req_if -> 6'b011111.
//  2 ex_branch=1, target=0x100, if_busy=0 -> both flushes=1 that cycle;
//    next cycle redirect_valid=1, addr=0x100, then 0.
//  3 ex_branch=1, target=0x2000, if_busy=1 for 3 more cycles -> HOLD;
//    stall_sign[0]=1 and flush_if_id=1 throughout;
//    redirect pulse with 0x2000 one cycle after if_busy falls.
//  4 ex_branch=1 with req_mem=1 -> no flush, no redirect;
//    branch accepted the cycle after req_mem drops.
//  5 CNT_W=4, stall held 20 cycles -> stall_cycles saturates at 15;
//    stall_clr=1 -> 0 next edge.
//  6 rst=0 asserted mid-HOLD between edges -> outputs reset immediately;
//    after release no redirect pulse, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges per-stage stall requests into stall_sign, flushes
// wrong-path instructions on taken branches and sequences the PC redirect.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal operation; a taken branch may redirect next cycle
// HOLD  | branch resolved while a fetch was outstanding; wait, then redirect
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_if,
  input  logic              req_id,
  input  logic              req_ex,
  input  logic              req_mem,
  input  logic              if_busy,
  input  logic              ex_branch,
  input  logic [ADDR_W-1:0] ex_target,
  output logic [5:0]        stall_sign,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pend_tgt;
  logic [5:0]        req_map;
  logic              hold;
  logic              accept;

  always_comb begin
    req_map = 6'b000000;
    if (req_mem)     req_map = 6'b011111;
    else if (req_ex) req_map = 6'b001111;
    else if (req_id) req_map = 6'b000111;
    else if (req_if) req_map = 6'b000011;
  end

  assign hold = (state == ST_HOLD);

  // Requests are masked while reset is held so the pipeline sees no stalls.
  assign stall_sign  = rst ? (req_map | {5'b00000, hold}) : 6'b000000;
  assign accept      = rst & ex_branch & ~stall_sign[4] & ~hold;
  assign flush_if_id = accept | hold;
  assign flush_id_ex = accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_RUN;
      pend_tgt       <= '0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (if_busy) begin
              pend_tgt <= ex_target;
              state    <= ST_HOLD;
            end else begin
              redirect_valid <= 1'b1;
              redirect_addr  <= ex_target;
            end
          end
        end
        ST_HOLD: begin
          if (!if_busy) begin
            redirect_valid <= 1'b1;
            redirect_addr  <= pend_tgt;
            state          <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if ((stall_sign != 6'b000000) && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: request-mapping table, directed branch/hold/saturation/reset
// sequences and randomized traffic, all compared against a cycle-level model.
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_if, req_id, req_ex, req_mem;
  logic              if_busy, ex_branch, stall_clr;
  logic [ADDR_W-1:0] ex_target;
  logic [5:0]        stall_sign;
  logic              flush_if_id, flush_id_ex, redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [CNT_W-1:0]  stall_cycles;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_hold;
  logic [31:0] m_tgt, m_ra;
  bit          m_rv;
  int          m_cnt;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_if(req_if), .req_id(req_id), .req_ex(req_ex), .req_mem(req_mem),
    .if_busy(if_busy), .ex_branch(ex_branch), .ex_target(ex_target),
    .stall_sign(stall_sign), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall_clr(stall_clr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] req_stall(input bit rm, input bit re, input bit ri, input bit rf);
    int n;
    n = rm ? 5 : re ? 4 : ri ? 3 : rf ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_hold = 0; m_tgt = 0; m_ra = 0; m_rv = 0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
    if_busy = 0; ex_branch = 0; ex_target = '0; stall_clr = 0;
  endtask

  // One clock: check everything mid-cycle against the model, then advance the model.
  task automatic cycle();
    logic [5:0] es;
    bit acc;
    @(negedge clk);
    es  = req_stall(req_mem, req_ex, req_id, req_if) | (m_hold ? 6'b000001 : 6'b000000);
    acc = ex_branch && !es[4] && !m_hold;
    chk("stall_sign", 32'(stall_sign), 32'(es));
    chk("flush_if_id", 32'(flush_if_id), 32'(acc || m_hold));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(acc));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_addr", redirect_addr, m_ra);
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clk);
    m_rv = 0;
    if (acc && !if_busy) begin
      m_rv = 1; m_ra = ex_target;
    end else if (acc) begin
      m_hold = 1; m_tgt = ex_target;
    end else if (m_hold && !if_busy) begin
      m_rv = 1; m_ra = m_tgt; m_hold = 0;
    end
    if (stall_clr) m_cnt = 0;
    else if (es != 0 && m_cnt < CNT_MAX) m_cnt++;
    #1;
  endtask

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [5:0] stall;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b0000, 6'b000000};
    vecs[1] = '{4'b0001, 6'b000011};
    vecs[2] = '{4'b0010, 6'b000111};
    vecs[3] = '{4'b0100, 6'b001111};
    vecs[4] = '{4'b1000, 6'b011111};
    vecs[5] = '{4'b1001, 6'b011111};
    vecs[6] = '{4'b0011, 6'b000111};
    vecs[7] = '{4'b0110, 6'b001111};
    vecs[8] = '{4'b1111, 6'b011111};
    vecs[9] = '{4'b0101, 6'b001111};

    idle_inputs();
    rst = 0;
    req_mem = 1;
    #3;
    chk("rst_stall_sign", 32'(stall_sign), 32'h0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_redirect_addr", redirect_addr, 32'h0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'h0);
    req_mem = 0;
    @(posedge clk); #1;
    rst = 1;
    model_reset();

    // request priority table
    foreach (vecs[i]) begin
      {req_mem, req_ex, req_id, req_if} = vecs[i].req;
      #1;
      chk($sformatf("table%0d_stall", i), 32'(stall_sign), 32'(vecs[i].stall));
      cycle();
    end
    idle_inputs();
    stall_clr = 1; cycle(); stall_clr = 0;

    // taken branch, no fetch outstanding
    ex_branch = 1; ex_target = 32'h100; #1;
    chk("br_flush_if_id", 32'(flush_if_id), 32'h1);
    chk("br_flush_id_ex", 32'(flush_id_ex), 32'h1);
    cycle();
    ex_branch = 0; #1;
    chk("br_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("br_redirect_addr", redirect_addr, 32'h100);
    cycle();
    chk("br_redirect_pulse_end", 32'(redirect_valid), 32'h0);
    cycle();

    // taken branch with fetch outstanding -> HOLD
    ex_branch = 1; ex_target = 32'h2000; if_busy = 1;
    cycle();
    ex_branch = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall0", 32'(stall_sign[0]), 32'h1);
      chk("hold_flush_if_id", 32'(flush_if_id), 32'h1);
      chk("hold_no_redirect", 32'(redirect_valid), 32'h0);
      cycle();
    end
    if_busy = 0; #1;
    chk("hold_exit_flush", 32'(flush_if_id), 32'h1);
    cycle();
    chk("hold_redirect_valid", 32'(redirect_valid), 32'h1);
    chk("hold_redirect_addr", redirect_addr, 32'h2000);
    cycle();

    // branch blocked by req_mem
    ex_branch = 1; ex_target = 32'h300; req_mem = 1; #1;
    chk("mem_block_flush", 32'(flush_id_ex), 32'h0);
    cycle();
    chk("mem_block_redirect", 32'(redirect_valid), 32'h0);
    cycle();
    req_mem = 0; #1;
    chk("mem_release_flush", 32'(flush_id_ex), 32'h1);
    cycle();
    ex_branch = 0;
    chk("mem_release_redirect", 32'(redirect_valid), 32'h1);
    chk("mem_release_addr", redirect_addr, 32'h300);
    cycle();

    // counter saturation and clear
    stall_clr = 1; cycle(); stall_clr = 0;
    req_id = 1;
    for (int k = 0; k < 20; k++) cycle();
    chk("cnt_saturated", 32'(stall_cycles), 32'(CNT_MAX));
    stall_clr = 1; cycle();
    chk("cnt_cleared", 32'(stall_cycles), 32'h0);
    stall_clr = 0; req_id = 0;
    cycle();

    // reset asserted mid-HOLD
    ex_branch = 1; ex_target = 32'h4444; if_busy = 1; req_if = 1;
    cycle();
    ex_branch = 0;
    cycle();
    #2;
    rst = 0;
    #1;
    chk("midrst_stall_sign", 32'(stall_sign), 32'h0);
    chk("midrst_flush_if_id", 32'(flush_if_id), 32'h0);
    chk("midrst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("midrst_stall_cycles", 32'(stall_cycles), 32'h0);
    @(posedge clk); #1;
    rst = 1; if_busy = 0; req_if = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("postrst_no_redirect", 32'(redirect_valid), 32'h0);
      chk("postrst_run", 32'(flush_if_id), 32'h0);
      cycle();
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_if    = ($urandom_range(0, 3) == 0);
      req_id    = ($urandom_range(0, 4) == 0);
      req_ex    = ($urandom_range(0, 5) == 0);
      req_mem   = ($urandom_range(0, 5) == 0);
      if_busy   = ($urandom_range(0, 1) == 0);
      ex_branch = ($urandom_range(0, 3) == 0);
      ex_target = $urandom;
      stall_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
